id_stage_pipe: RTL

Parametrised MIPS decode stage with its own ID/EX pipeline register, valid/ready handshakes on both sides, EX/MEM operand forwarding, load-use stall detection, branch/jump resolution in ID and delay-slot tagging. It sits between the IF/ID register and the EX stage. It replaces a purely combinational decoder so that stall, flush and back-pressure are handled inside the stage.

---
 rtl/id_stage_pipe.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with its own ID/EX register.
// It contains the valid/ready handshakes, operand selection, hazard stalls,
// branch/jump resolution and delay-slot tagging.
// Optional feature macro: ID_BYPASS_EN. When it is defined, EX/MEM results
// are forwarded and only load-use hazards stall. When it is undefined,
// operands come only from the regfile and any pending EX/MEM write to a
// read register stalls.
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   pc_i,
  input  logic [31:0]         inst_i,
  input  logic                flush_i,
  output logic [REG_AW-1:0]   reg1_addr_o,
  output logic [REG_AW-1:0]   reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic                ex_is_load_i,
  input  logic [REG_AW-1:0]   ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                mem_wreg_i,
  input  logic [REG_AW-1:0]   mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic                branch_flag_o,
  output logic [DATA_W-1:0]   branch_target_o,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [DATA_W-1:0]   link_addr_o,
  output logic [REG_AW-1:0]   wd_o,
  output logic                wreg_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                in_delay_slot_o,
  output logic [DATA_W-1:0]   pc_o,
  output logic [31:0]         inst_o
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_J    = 6'b000010, OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100, OP_BNE  = 6'b000101, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101, OP_XORI = 6'b001110, OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011, OP_SW   = 6'b101011;
  // SPECIAL function codes
  localparam logic [5:0] FN_SLL = 6'b000000, FN_SRL = 6'b000010, FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000, FN_JALR = 6'b001001, FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110, FN_NOR = 6'b100111, FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  // ALU operation codes (0 is the NOP bubble)
  localparam logic [7:0] ALU_NOP  = 8'h00, ALU_AND = 8'h24, ALU_OR   = 8'h25, ALU_XOR = 8'h26;
  localparam logic [7:0] ALU_NOR  = 8'h27, ALU_ADDU = 8'h21, ALU_SUBU = 8'h23, ALU_SLT = 8'h2A;
  localparam logic [7:0] ALU_SLTU = 8'h2B, ALU_SLL = 8'h7C, ALU_SRL  = 8'h02, ALU_SRA = 8'h03;
  localparam logic [7:0] ALU_LW   = 8'hE3, ALU_SW  = 8'hEB, ALU_J    = 8'h4F, ALU_JAL = 8'h50;
  localparam logic [7:0] ALU_JR   = 8'h08, ALU_JALR = 8'h09, ALU_BEQ = 8'h51, ALU_BNE = 8'h52;
  // Result select codes
  localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100, SEL_JB = 3'b110, SEL_LS = 3'b111;

  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_J, BR_JR} br_kind_t;

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s, sa_s;
  logic [15:0] imm_s;
  logic [DATA_W-1:0] sext_s, zext_s, pc_plus4_s, pc_plus8_s, br_off_s;

  assign op_s       = inst_i[31:26];
  assign rs_s       = inst_i[25:21];
  assign rt_s       = inst_i[20:16];
  assign rd_s       = inst_i[15:11];
  assign sa_s       = inst_i[10:6];
  assign funct_s    = inst_i[5:0];
  assign imm_s      = inst_i[15:0];
  assign sext_s     = {{(DATA_W-16){imm_s[15]}}, imm_s};
  assign zext_s     = {{(DATA_W-16){1'b0}}, imm_s};
  assign br_off_s   = {{(DATA_W-18){imm_s[15]}}, imm_s, 2'b00};
  assign pc_plus4_s = pc_i + DATA_W'(32'd4);
  assign pc_plus8_s = pc_i + DATA_W'(32'd8);

  assign reg1_addr_o = REG_AW'(rs_s);
  assign reg2_addr_o = REG_AW'(rt_s);

  logic [7:0]        aluop_s;
  logic [2:0]        alusel_s;
  logic              wreg_s, r1_read_s, r2_read_s, is_load_s, is_store_s, is_br_s, link_s;
  logic [REG_AW-1:0] wd_s;
  logic [DATA_W-1:0] imm1_s, imm2_s;
  br_kind_t          br_kind_s;

  // Instruction decode: op, destination, which ports are read, immediates
  always_comb begin
    aluop_s = ALU_NOP; alusel_s = SEL_NOP; wreg_s = 1'b0; wd_s = '0;
    r1_read_s = 1'b0; r2_read_s = 1'b0; imm1_s = '0; imm2_s = '0;
    is_load_s = 1'b0; is_store_s = 1'b0; is_br_s = 1'b0; link_s = 1'b0;
    br_kind_s = BR_NONE;
    case (op_s)
      OP_ORI:   begin aluop_s = ALU_OR;  alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = zext_s; end
      OP_ANDI:  begin aluop_s = ALU_AND; alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = zext_s; end
      OP_XORI:  begin aluop_s = ALU_XOR; alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = zext_s; end
      OP_LUI:   begin aluop_s = ALU_OR;  alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); imm2_s = {imm_s, {(DATA_W-16){1'b0}}}; end
      OP_ADDIU: begin aluop_s = ALU_ADDU; alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = sext_s; end
      OP_SLTI:  begin aluop_s = ALU_SLT;  alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = sext_s; end
      OP_SLTIU: begin aluop_s = ALU_SLTU; alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = sext_s; end
      OP_LW:    begin aluop_s = ALU_LW; alusel_s = SEL_LS; wreg_s = 1'b1; wd_s = REG_AW'(rt_s); r1_read_s = 1'b1; imm2_s = sext_s; is_load_s = 1'b1; end
      OP_SW:    begin aluop_s = ALU_SW; alusel_s = SEL_LS; r1_read_s = 1'b1; r2_read_s = 1'b1; is_store_s = 1'b1; end
      OP_J:     begin aluop_s = ALU_J;   alusel_s = SEL_JB; is_br_s = 1'b1; br_kind_s = BR_J; end
      OP_JAL:   begin aluop_s = ALU_JAL; alusel_s = SEL_JB; is_br_s = 1'b1; br_kind_s = BR_J;
                      wreg_s = 1'b1; wd_s = REG_AW'(5'd31); link_s = 1'b1; end
      OP_BEQ:   begin aluop_s = ALU_BEQ; alusel_s = SEL_JB; is_br_s = 1'b1; br_kind_s = BR_EQ; r1_read_s = 1'b1; r2_read_s = 1'b1; end
      OP_BNE:   begin aluop_s = ALU_BNE; alusel_s = SEL_JB; is_br_s = 1'b1; br_kind_s = BR_NE; r1_read_s = 1'b1; r2_read_s = 1'b1; end
      OP_SPECIAL: begin
        case (funct_s)
          FN_AND:  begin aluop_s = ALU_AND;  alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_OR:   begin aluop_s = ALU_OR;   alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_XOR:  begin aluop_s = ALU_XOR;  alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_NOR:  begin aluop_s = ALU_NOR;  alusel_s = SEL_LOGIC; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_ADDU: begin aluop_s = ALU_ADDU; alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_SUBU: begin aluop_s = ALU_SUBU; alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_SLT:  begin aluop_s = ALU_SLT;  alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_SLTU: begin aluop_s = ALU_SLTU; alusel_s = SEL_ARITH; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r1_read_s = 1'b1; r2_read_s = 1'b1; end
          FN_SLL:  begin aluop_s = ALU_SLL;  alusel_s = SEL_SHIFT; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r2_read_s = 1'b1; imm1_s = DATA_W'(sa_s); end
          FN_SRL:  begin aluop_s = ALU_SRL;  alusel_s = SEL_SHIFT; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r2_read_s = 1'b1; imm1_s = DATA_W'(sa_s); end
          FN_SRA:  begin aluop_s = ALU_SRA;  alusel_s = SEL_SHIFT; wreg_s = 1'b1; wd_s = REG_AW'(rd_s); r2_read_s = 1'b1; imm1_s = DATA_W'(sa_s); end
          FN_JR:   begin aluop_s = ALU_JR;   alusel_s = SEL_JB; is_br_s = 1'b1; br_kind_s = BR_JR; r1_read_s = 1'b1; end
          FN_JALR: begin aluop_s = ALU_JALR; alusel_s = SEL_JB; is_br_s = 1'b1; br_kind_s = BR_JR; r1_read_s = 1'b1;
                         wreg_s = 1'b1; wd_s = REG_AW'(rd_s); link_s = 1'b1; end
          default: begin aluop_s = ALU_NOP; wreg_s = 1'b0; end
        endcase
      end
      default: begin aluop_s = ALU_NOP; wreg_s = 1'b0; end
    endcase
  end

  logic [DATA_W-1:0] fwd1_s, fwd2_s;
  logic              haz1_s, haz2_s, stall_s;

`ifdef ID_BYPASS_EN
  // Port 1 operand: r0, then EX result, then MEM result, then regfile
  always_comb begin
    if (reg1_addr_o == '0)                        fwd1_s = '0;
    else if (ex_wreg_i && ex_wd_i == reg1_addr_o)   fwd1_s = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == reg1_addr_o) fwd1_s = mem_wdata_i;
    else                                          fwd1_s = reg1_data_i;
  end

  // Port 2 operand: same priority as port 1
  always_comb begin
    if (reg2_addr_o == '0)                        fwd2_s = '0;
    else if (ex_wreg_i && ex_wd_i == reg2_addr_o)   fwd2_s = ex_wdata_i;
    else if (mem_wreg_i && mem_wd_i == reg2_addr_o) fwd2_s = mem_wdata_i;
    else                                          fwd2_s = reg2_data_i;
  end

  // Only a load in EX cannot be bypassed: its data is not ready yet
  always_comb begin
    haz1_s = r1_read_s && (reg1_addr_o != '0) && ex_is_load_i && ex_wreg_i && (ex_wd_i == reg1_addr_o);
    haz2_s = r2_read_s && (reg2_addr_o != '0) && ex_is_load_i && ex_wreg_i && (ex_wd_i == reg2_addr_o);
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};

  // Operands straight from the regfile, r0 forced to zero
  always_comb begin
    if (reg1_addr_o == '0) fwd1_s = '0;
    else                   fwd1_s = reg1_data_i;
    if (reg2_addr_o == '0) fwd2_s = '0;
    else                   fwd2_s = reg2_data_i;
  end

  // Without bypass any in-flight write to a read register must retire first
  always_comb begin
    haz1_s = r1_read_s && (reg1_addr_o != '0) &&
             ((ex_wreg_i && ex_wd_i == reg1_addr_o) || (mem_wreg_i && mem_wd_i == reg1_addr_o));
    haz2_s = r2_read_s && (reg2_addr_o != '0) &&
             ((ex_wreg_i && ex_wd_i == reg2_addr_o) || (mem_wreg_i && mem_wd_i == reg2_addr_o));
  end
`endif

  logic out_valid_q, accept_s;
  assign stall_s  = in_valid && (haz1_s || haz2_s);
  assign in_ready = !stall_s && (!out_valid_q || out_ready) && !flush_i;
  assign accept_s = in_valid && in_ready;

  logic              taken_s;
  logic [DATA_W-1:0] target_s;

  // Branch/jump resolution on the forwarded operands
  always_comb begin
    taken_s  = 1'b0;
    target_s = '0;
    case (br_kind_s)
      BR_EQ:   begin taken_s = (fwd1_s == fwd2_s); target_s = pc_plus4_s + br_off_s; end
      BR_NE:   begin taken_s = (fwd1_s != fwd2_s); target_s = pc_plus4_s + br_off_s; end
      BR_J:    begin taken_s = 1'b1; target_s = {pc_plus4_s[DATA_W-1:28], inst_i[25:0], 2'b00}; end
      BR_JR:   begin taken_s = 1'b1; target_s = fwd1_s; end
      default: begin taken_s = 1'b0; target_s = '0; end
    endcase
  end

  // A redirect only counts for an instruction actually leaving ID
  assign branch_flag_o   = accept_s && taken_s && !rst;
  assign branch_target_o = target_s;

  logic [ALUOP_W-1:0]  aluop_q, aluop_d;
  logic [ALUSEL_W-1:0] alusel_q, alusel_d;
  logic [DATA_W-1:0]   reg1_q, reg1_d, reg2_q, reg2_d, link_q, link_d, pc_q, pc_d;
  logic [REG_AW-1:0]   wd_q, wd_d;
  logic [31:0]         inst_q, inst_d;
  logic                out_valid_d, wreg_q, wreg_d, ld_q, ld_d, st_q, st_d;
  logic                ds_q, ds_d, ds_next_q, ds_next_d;

  // ID/EX next state: flush empties, accept loads, drain empties, else hold
  always_comb begin
    out_valid_d = out_valid_q; aluop_d = aluop_q; alusel_d = alusel_q;
    reg1_d = reg1_q; reg2_d = reg2_q; link_d = link_q; wd_d = wd_q;
    wreg_d = wreg_q; ld_d = ld_q; st_d = st_q; ds_d = ds_q;
    pc_d = pc_q; inst_d = inst_q; ds_next_d = ds_next_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      ds_next_d   = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      aluop_d     = ALUOP_W'(aluop_s);
      alusel_d    = ALUSEL_W'(alusel_s);
      reg1_d      = r1_read_s ? fwd1_s : imm1_s;
      reg2_d      = r2_read_s ? fwd2_s : imm2_s;
      link_d      = link_s ? pc_plus8_s : '0;
      wd_d        = wd_s;
      wreg_d      = wreg_s;
      ld_d        = is_load_s;
      st_d        = is_store_s;
      ds_d        = ds_next_q;
      pc_d        = pc_i;
      inst_d      = inst_i;
      ds_next_d   = is_br_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0; aluop_q <= '0; alusel_q <= '0;
      reg1_q <= '0; reg2_q <= '0; link_q <= '0; wd_q <= '0;
      wreg_q <= 1'b0; ld_q <= 1'b0; st_q <= 1'b0; ds_q <= 1'b0;
      pc_q <= RESET_PC; inst_q <= 32'h0000_0000; ds_next_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d; aluop_q <= aluop_d; alusel_q <= alusel_d;
      reg1_q <= reg1_d; reg2_q <= reg2_d; link_q <= link_d; wd_q <= wd_d;
      wreg_q <= wreg_d; ld_q <= ld_d; st_q <= st_d; ds_q <= ds_d;
      pc_q <= pc_d; inst_q <= inst_d; ds_next_q <= ds_next_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign aluop_o         = aluop_q;
  assign alusel_o        = alusel_q;
  assign reg1_o          = reg1_q;
  assign reg2_o          = reg2_q;
  assign link_addr_o     = link_q;
  assign wd_o            = wd_q;
  assign wreg_o          = wreg_q;
  assign is_load_o       = ld_q;
  assign is_store_o      = st_q;
  assign in_delay_slot_o = ds_q;
  assign pc_o            = pc_q;
  assign inst_o          = inst_q;

endmodule
